dcache_mem_responder: RTL and testbench



---
 rtl/dcache_mem_responder_if.sv | 28 ++
 rtl/dcache_mem_responder.sv | 120 ++++++++++++
 tb/tb_dcache_mem_responder.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_mem_responder_if.sv
// D-cache <-> memory port bundle; the cache drives the master side, the responder the slave side.
// Single outstanding request; the held req is the only backpressure, answered by addrOK.
interface dcache_mem_responder_if #(
  parameter int offset_width = 2
);
  logic [31:0]                       addr_dcache_mem;
  logic [31:0]                       dout_dcache_mem;
  logic                              dcache_mem_req;
  logic                              dcache_mem_wr;
  logic [1:0]                        dcache_mem_size;
  logic [3:0]                        dcache_mem_wstrb;
  logic [32*(2**offset_width)-1:0]   din_mem_dcache;
  logic                              mem_dcache_addrOK;
  logic                              mem_dcache_dataOK;
  logic                              mem_dcache_bvalid;

  modport master (
    output addr_dcache_mem, dout_dcache_mem, dcache_mem_req, dcache_mem_wr,
           dcache_mem_size, dcache_mem_wstrb,
    input  din_mem_dcache, mem_dcache_addrOK, mem_dcache_dataOK, mem_dcache_bvalid
  );

  modport slave (
    input  addr_dcache_mem, dout_dcache_mem, dcache_mem_req, dcache_mem_wr,
           dcache_mem_size, dcache_mem_wstrb,
    output din_mem_dcache, mem_dcache_addrOK, mem_dcache_dataOK, mem_dcache_bvalid
  );
endinterface

// File: rtl/dcache_mem_responder.sv
// On-chip RAM target for the D-cache port: line refills and byte-masked word writes.
// Read response T+L+N+1, write T+L+2; addrOK only in IDLE, so a held req simply waits.
module dcache_mem_responder #(
  parameter int offset_width = 2,
  parameter int mem_aw       = 12,
  parameter int resp_latency = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  dcache_mem_responder_if.slave mem
);

  localparam int N  = 1 << offset_width;
  localparam int CW = (resp_latency > 1) ? $clog2(resp_latency + 1) : 1;
  localparam logic [offset_width-1:0] BEAT_ONE  = 1;
  localparam logic [offset_width-1:0] BEAT_LAST = offset_width'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_RFILL, S_RDONE, S_WMEM, S_WRESP
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [offset_width-1:0] beat_q, beat_d;
  logic [mem_aw-1:0]       idx_q;
  logic [31:0]             wdat_q;
  logic                    wr_q;
  logic [3:0]              mask_q;
  logic [32*N-1:0]         line_q;
  logic [31:0]             ram_mem [2**mem_aw];

  logic                    accept;
  logic [mem_aw-1:0]       rd_idx;
  logic                    unused_addr_bits;

  function automatic logic [3:0] req_mask(input logic [3:0] wstrb,
                                          input logic [1:0] size,
                                          input logic [1:0] lo);
    if (wstrb != 4'b0000) return wstrb;
    case (size)
      2'd0:    return 4'b0001 << lo;
      2'd1:    return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  assign accept           = (state_q == S_IDLE) && mem.dcache_mem_req;
  assign rd_idx           = {idx_q[mem_aw-1:offset_width], beat_q};
  assign unused_addr_bits = ^mem.addr_dcache_mem[31:mem_aw+2];

  assign mem.mem_dcache_addrOK = rstn && accept;
  assign mem.mem_dcache_dataOK = (state_q == S_RDONE);
  assign mem.mem_dcache_bvalid = (state_q == S_WRESP);
  assign mem.din_mem_dcache    = line_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (mem.dcache_mem_req) begin
          cnt_d  = CW'(resp_latency);
          beat_d = '0;
          if (resp_latency > 0) state_d = S_WAIT;
          else                  state_d = mem.dcache_mem_wr ? S_WMEM : S_RFILL;
        end
      end
      S_WAIT: begin
        if (cnt_q == CW'(1)) state_d = wr_q ? S_WMEM : S_RFILL;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      S_RFILL: begin
        beat_d = beat_q + BEAT_ONE;
        if (beat_q == BEAT_LAST) state_d = S_RDONE;
      end
      S_RDONE: state_d = S_IDLE;
      S_WMEM:  state_d = S_WRESP;
      S_WRESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      idx_q   <= '0;
      wdat_q  <= '0;
      wr_q    <= 1'b0;
      mask_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      // Request fields are captured once; later changes on the bus are ignored.
      if (accept) begin
        idx_q  <= mem.addr_dcache_mem[mem_aw+1:2];
        wdat_q <= mem.dout_dcache_mem;
        wr_q   <= mem.dcache_mem_wr;
        mask_q <= req_mask(mem.dcache_mem_wstrb, mem.dcache_mem_size,
                           mem.addr_dcache_mem[1:0]);
      end
      if (state_q == S_RFILL) line_q[32*beat_q +: 32] <= ram_mem[rd_idx];
    end
  end

  // RAM is outside reset; an interrupted write never reaches WMEM, so it is all-or-nothing.
  always_ff @(posedge clk) begin
    if (state_q == S_WMEM) begin
      if (mask_q[0]) ram_mem[idx_q][7:0]   <= wdat_q[7:0];
      if (mask_q[1]) ram_mem[idx_q][15:8]  <= wdat_q[15:8];
      if (mask_q[2]) ram_mem[idx_q][23:16] <= wdat_q[23:16];
      if (mask_q[3]) ram_mem[idx_q][31:24] <= wdat_q[31:24];
    end
  end

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Bench for dcache_mem_responder: two instances (latency 2 and 0) sharing one stimulus bus.
// Directed vector table, hand-written reset/back-to-back sequences, then random traffic vs a RAM model.
module tb_dcache_mem_responder;

  localparam int OW = 2;
  localparam int AW = 12;
  localparam int N  = 4;
  localparam int LW = 32 * N;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  dcache_mem_responder_if #(.offset_width(OW)) if0 ();
  dcache_mem_responder_if #(.offset_width(OW)) if1 ();

  dcache_mem_responder #(.offset_width(OW), .mem_aw(AW), .resp_latency(2)) u_lat2 (
    .clk(clk), .rstn(rstn), .mem(if0)
  );
  dcache_mem_responder #(.offset_width(OW), .mem_aw(AW), .resp_latency(0)) u_lat0 (
    .clk(clk), .rstn(rstn), .mem(if1)
  );

  logic        sel = 1'b0;
  logic [31:0] a_r = '0, d_r = '0;
  logic        req_r = 1'b0, wr_r = 1'b0;
  logic [1:0]  sz_r = '0;
  logic [3:0]  st_r = '0;

  assign if0.addr_dcache_mem  = a_r;
  assign if0.dout_dcache_mem  = d_r;
  assign if0.dcache_mem_req   = req_r & ~sel;
  assign if0.dcache_mem_wr    = wr_r;
  assign if0.dcache_mem_size  = sz_r;
  assign if0.dcache_mem_wstrb = st_r;
  assign if1.addr_dcache_mem  = a_r;
  assign if1.dout_dcache_mem  = d_r;
  assign if1.dcache_mem_req   = req_r & sel;
  assign if1.dcache_mem_wr    = wr_r;
  assign if1.dcache_mem_size  = sz_r;
  assign if1.dcache_mem_wstrb = st_r;

  logic          addrok, dataok, bvalid;
  logic [LW-1:0] din;
  assign addrok = sel ? if1.mem_dcache_addrOK : if0.mem_dcache_addrOK;
  assign dataok = sel ? if1.mem_dcache_dataOK : if0.mem_dcache_dataOK;
  assign bvalid = sel ? if1.mem_dcache_bvalid : if0.mem_dcache_bvalid;
  assign din    = sel ? if1.din_mem_dcache    : if0.din_mem_dcache;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference RAM images, one per instance.
  logic [31:0] m0 [4096];
  logic [31:0] m1 [4096];

  task automatic chk(input string nm, input int idx, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  // Byte mask from access size: nb bytes, naturally aligned within the word.
  function automatic logic [3:0] ref_mask(input logic [3:0] st, input logic [1:0] sz,
                                          input logic [1:0] lo);
    int nb, first;
    if (st != 4'b0) return st;
    nb    = (sz >= 2) ? 4 : (1 << sz);
    first = (int'(lo) / nb) * nb;
    return 4'(((1 << nb) - 1) << first);
  endfunction

  task automatic model_write(input bit s, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz, input logic [3:0] st);
    logic [11:0] ix;
    logic [31:0] w;
    logic [3:0]  m;
    ix = a[13:2];
    w  = s ? m1[ix] : m0[ix];
    m  = ref_mask(st, sz, a[1:0]);
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    if (s) m1[ix] = w;
    else   m0[ix] = w;
  endtask

  function automatic logic [LW-1:0] model_line(input bit s, input logic [31:0] a);
    logic [LW-1:0] l;
    logic [11:0]   ix;
    l = '0;
    for (int k = 0; k < N; k++) begin
      ix = (a[13:2] & 12'hFFC) + 12'(k);
      l[32*k +: 32] = s ? m1[ix] : m0[ix];
    end
    return l;
  endfunction

  function automatic int exp_lat(input bit s, input bit w);
    return (s ? 0 : 2) + (w ? 2 : N + 1);
  endfunction

  task automatic do_txn(input bit s, input logic [31:0] a, input logic [31:0] d,
                        input bit w, input logic [1:0] sz, input logic [3:0] st,
                        output bit acc, output int lat, output logic [LW-1:0] line);
    acc  = 1'b0;
    lat  = -1;
    line = '0;
    sel = s; a_r = a; d_r = d; wr_r = w; sz_r = sz; st_r = st; req_r = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = (addrok === 1'b1);
    end
    @(posedge clk);
    #1;
    req_r = 1'b0;
    a_r = $urandom; d_r = $urandom; st_r = 4'($urandom); sz_r = 2'($urandom);
    wr_r = 1'($urandom);
    if (acc) begin
      for (int k = 1; k <= 40 && lat < 0; k++) begin
        @(negedge clk);
        if ((w ? bvalid : dataok) === 1'b1) begin
          lat  = k;
          line = din;
        end
      end
    end
  endtask

  typedef struct {
    bit            s;
    logic [31:0]   a;
    logic [31:0]   d;
    bit            w;
    logic [1:0]    sz;
    logic [3:0]    st;
    int            lat;
    logic [LW-1:0] line;
  } vec_t;

  vec_t tbl [15];

  initial begin
    bit            acc;
    int            lat;
    logic [LW-1:0] line;
    bit            seen;

    for (int i = 0; i < 4096; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end

    tbl[0]  = '{0, 32'h40,   32'hDEADBEEF, 1, 2'd2, 4'hF, 4, '0};
    tbl[1]  = '{0, 32'h48,   32'h0,        0, 2'd2, 4'h0, 7, 128'hDEADBEEF};
    tbl[2]  = '{0, 32'h40,   32'h11223344, 1, 2'd2, 4'hF, 4, '0};
    tbl[3]  = '{0, 32'h41,   32'h0000AA00, 1, 2'd0, 4'h2, 4, '0};
    tbl[4]  = '{0, 32'h40,   32'h0,        0, 2'd2, 4'h0, 7, 128'h1122AA44};
    tbl[5]  = '{0, 32'h42,   32'h55660000, 1, 2'd1, 4'h0, 4, '0};
    tbl[6]  = '{0, 32'h4C,   32'h0,        0, 2'd2, 4'h0, 7, 128'h5566AA44};
    tbl[7]  = '{0, 32'h44,   32'hA5A5A5A5, 1, 2'd2, 4'hF, 4, '0};
    tbl[8]  = '{0, 32'h40,   32'h0,        0, 2'd2, 4'h0, 7,
                128'h00000000_00000000_A5A5A5A5_5566AA44};
    tbl[9]  = '{1, 32'h4000, 32'hCAFEF00D, 1, 2'd2, 4'hF, 2, '0};
    tbl[10] = '{1, 32'h0,    32'h0,        0, 2'd2, 4'h0, 5, 128'hCAFEF00D};
    tbl[11] = '{1, 32'h3,    32'h77000000, 1, 2'd0, 4'h0, 2, '0};
    tbl[12] = '{1, 32'h4008, 32'h0,        0, 2'd2, 4'h0, 5, 128'h77FEF00D};
    tbl[13] = '{1, 32'h4,    32'h00001234, 1, 2'd1, 4'h0, 2, '0};
    tbl[14] = '{1, 32'h0,    32'h0,        0, 2'd2, 4'h0, 5,
                128'h00000000_00000000_00001234_77FEF00D};

    // Reset with a request already pending.
    sel = 1'b0; a_r = 32'h40; wr_r = 1'b0; req_r = 1'b1;
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addrok", 0, LW'(addrok), LW'(0));
    chk("rst_dataok", 0, LW'(dataok), LW'(0));
    chk("rst_bvalid", 0, LW'(bvalid), LW'(0));
    chk("rst_din",    0, din, '0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_addrok", 0, LW'(addrok), LW'(1));
    req_r = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      do_txn(tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].w, tbl[i].sz, tbl[i].st, acc, lat, line);
      chk("tbl_accept", i, LW'(acc), LW'(1));
      chk("tbl_lat", i, LW'(lat), LW'(tbl[i].lat));
      if (tbl[i].w) model_write(tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].sz, tbl[i].st);
      else          chk("tbl_line", i, line, tbl[i].line);
    end

    // Request held across a read: no accept until the cycle after dataOK.
    sel = 1'b0; a_r = 32'h40; wr_r = 1'b0; sz_r = 2'd2; st_r = 4'h0; req_r = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = (addrok === 1'b1);
    end
    chk("b2b_accept", 0, LW'(acc), LW'(1));
    lat = -1;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      @(negedge clk);
      chk("b2b_busy", k, LW'(addrok), LW'(0));
      if (dataok === 1'b1) lat = k;
    end
    chk("b2b_lat1", 0, LW'(lat), LW'(7));
    @(negedge clk);
    chk("b2b_reaccept", 0, LW'(addrok), LW'(1));
    @(posedge clk);
    #1 req_r = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      @(negedge clk);
      if (dataok === 1'b1) begin
        lat  = k;
        line = din;
      end
    end
    chk("b2b_lat2", 0, LW'(lat), LW'(7));
    chk("b2b_line2", 0, line, model_line(0, 32'h40));

    // Reset during refill beat 2 drops the read.
    sel = 1'b0; a_r = 32'h40; wr_r = 1'b0; req_r = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = (addrok === 1'b1);
    end
    chk("midrst_accept", 0, LW'(acc), LW'(1));
    @(posedge clk);
    #1 req_r = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= (dataok === 1'b1);
    end
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_din", 0, din, '0);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (10) begin
      @(negedge clk);
      seen |= (dataok === 1'b1);
    end
    chk("midrst_no_dataok", 0, LW'(seen), LW'(0));
    do_txn(0, 32'h40, 32'h0, 0, 2'd2, 4'h0, acc, lat, line);
    chk("midrst_rd_lat", 0, LW'(lat), LW'(7));
    chk("midrst_rd_line", 0, line, model_line(0, 32'h40));
    do_txn(1, 32'h0, 32'h0, 0, 2'd2, 4'h0, acc, lat, line);
    chk("midrst_rd1_line", 0, line, model_line(1, 32'h0));

    // Random traffic over a small aliased window.
    for (int i = 0; i < 150; i++) begin
      bit          s, w;
      logic [31:0] a, d;
      logic [1:0]  sz;
      logic [3:0]  st;
      s  = 1'($urandom);
      w  = 1'($urandom);
      a  = $urandom & 32'hFFFF_C03F;
      d  = $urandom;
      sz = 2'($urandom);
      st = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      do_txn(s, a, d, w, sz, st, acc, lat, line);
      chk("rnd_accept", i, LW'(acc), LW'(1));
      chk("rnd_lat", i, LW'(lat), LW'(exp_lat(s, w)));
      if (w) model_write(s, a, d, sz, st);
      else   chk("rnd_line", i, line, model_line(s, a));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached after %0d comparisons", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
